// File: rtl/l1_instr_line_fill.sv
// rtl/l1_instr_line_fill.sv - L1 instruction cache line refill engine over a 32-bit read bus
module l1_instr_line_fill #(
    parameter int LINE_BYTES      = 16,
    parameter int LINE_ADDR_WIDTH = 28,
    parameter int TAG_WIDTH       = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       l1_req_valid_i,
    input  logic                       l1_req_rw_i,
    input  logic [LINE_BYTES-1:0]      l1_req_byteen_i,
    input  logic [LINE_ADDR_WIDTH-1:0] l1_req_addr_i,
    input  logic [LINE_BYTES*8-1:0]    l1_req_data_i,
    input  logic [TAG_WIDTH-1:0]       l1_req_tag_i,
    output logic                       l1_req_ready_o,
    output logic                       l1_rsp_valid_o,
    output logic [LINE_BYTES*8-1:0]    l1_rsp_data_o,
    output logic [TAG_WIDTH-1:0]       l1_rsp_tag_o,
    input  logic                       l1_rsp_ready_i,
    output logic                       bus_req_o,
    output logic [31:0]                bus_addr_o,
    input  logic                       bus_gnt_i,
    input  logic                       bus_rvalid_i,
    input  logic [31:0]                bus_rdata_i,
    output logic                       wr_err_o
);
    localparam int BEATS  = LINE_BYTES / 4;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int OFFS   = $clog2(LINE_BYTES);
    localparam int CW     = $clog2(BEATS) + 1;
    localparam int FULL_W = LINE_ADDR_WIDTH + OFFS;
    localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
    localparam logic [CW-1:0] LAST_C  = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [LINE_ADDR_WIDTH-1:0] addr_q;
    logic [TAG_WIDTH-1:0]       tag_q;
    logic [CW-1:0]              issued_q;
    logic [CW-1:0]              rcvd_q;
    logic [LINE_W-1:0]          line_q;
    logic                       wr_err_q;

    // Byte address of the line padded well past 32 bits so truncation is explicit
    logic [FULL_W+31:0] base_ext;
    logic [31:0]        beat_off;
    logic               unused_ok;

    assign base_ext  = {32'd0, addr_q, {OFFS{1'b0}}};
    assign beat_off  = 32'({issued_q, 2'b00});
    assign unused_ok = ^{l1_req_byteen_i, l1_req_data_i, base_ext[FULL_W+31:32]};

    assign l1_req_ready_o = (state_q == IDLE);
    assign l1_rsp_valid_o = (state_q == RESP);
    assign l1_rsp_data_o  = line_q;
    assign l1_rsp_tag_o   = tag_q;
    assign wr_err_o       = wr_err_q;
    assign bus_req_o      = (state_q == FETCH) && (issued_q < BEATS_C);
    assign bus_addr_o     = bus_req_o ? (base_ext[31:0] + beat_off) : 32'd0;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: reads start a fetch, writes are flagged and dropped in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (l1_req_valid_i && !l1_req_rw_i) state_d = FETCH;
            FETCH:   if (bus_rvalid_i && (rcvd_q == LAST_C)) state_d = RESP;
            RESP:    if (l1_rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, beat counters, line assembly and sticky write error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            tag_q    <= '0;
            issued_q <= '0;
            rcvd_q   <= '0;
            line_q   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            if ((state_q == IDLE) && l1_req_valid_i) begin
                if (l1_req_rw_i) begin
                    wr_err_q <= 1'b1;
                end else begin
                    addr_q   <= l1_req_addr_i;
                    tag_q    <= l1_req_tag_i;
                    issued_q <= '0;
                    rcvd_q   <= '0;
                end
            end
            if (bus_req_o && bus_gnt_i) begin
                issued_q <= issued_q + CW'(1);
            end
            if ((state_q == FETCH) && bus_rvalid_i && (rcvd_q < BEATS_C)) begin
                for (int i = 0; i < BEATS; i++) begin
                    if (rcvd_q == CW'(i)) line_q[32*i +: 32] <= bus_rdata_i;
                end
                rcvd_q <= rcvd_q + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_l1_instr_line_fill.sv
// tb/tb_l1_instr_line_fill.sv - self-checking bench for l1_instr_line_fill
module tb_l1_instr_line_fill;
    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          l1_req_valid_i;
    logic          l1_req_rw_i;
    logic [15:0]   l1_req_byteen_i;
    logic [27:0]   l1_req_addr_i;
    logic [127:0]  l1_req_data_i;
    logic [7:0]    l1_req_tag_i;
    logic          l1_req_ready_o;
    logic          l1_rsp_valid_o;
    logic [127:0]  l1_rsp_data_o;
    logic [7:0]    l1_rsp_tag_o;
    logic          l1_rsp_ready_i;
    logic          bus_req_o;
    logic [31:0]   bus_addr_o;
    logic          bus_gnt_i;
    logic          bus_rvalid_i;
    logic [31:0]   bus_rdata_i;
    logic          wr_err_o;

    int checks = 0;
    int errors = 0;

    l1_instr_line_fill dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .l1_req_valid_i(l1_req_valid_i), .l1_req_rw_i(l1_req_rw_i),
        .l1_req_byteen_i(l1_req_byteen_i), .l1_req_addr_i(l1_req_addr_i),
        .l1_req_data_i(l1_req_data_i), .l1_req_tag_i(l1_req_tag_i),
        .l1_req_ready_o(l1_req_ready_o), .l1_rsp_valid_o(l1_rsp_valid_o),
        .l1_rsp_data_o(l1_rsp_data_o), .l1_rsp_tag_o(l1_rsp_tag_o),
        .l1_rsp_ready_i(l1_rsp_ready_i), .bus_req_o(bus_req_o),
        .bus_addr_o(bus_addr_o), .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .wr_err_o(wr_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [27:0]       addr;
        logic [7:0]        tag;
        logic [3:0][31:0]  d;
        logic [7:0]        gnt_stall;
        logic [7:0]        rsp_stall;
        logic [31:0]       exp_addr0;
        logic [127:0]      exp_line;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Runs one read refill starting at a falling edge and ends at a falling edge.
    // The bus responder grants after gnt_stall idle cycles (or randomly when rnd)
    // and returns data in grant order, at least one cycle after each grant.
    task automatic refill(input string nm, input logic [27:0] addr, input logic [7:0] tag,
                          input logic [3:0][31:0] d, input int gnt_stall, input int rsp_stall,
                          input bit rnd, input logic [31:0] exp_addr0, input logic [127:0] exp_line);
        int issued = 0;
        int rcvd = 0;
        int cyc;
        int stall = 0;
        int due_q[$];
        int idx_q[$];
        logic g;
        l1_req_valid_i = 1'b1;
        l1_req_rw_i    = 1'b0;
        l1_req_addr_i  = addr;
        l1_req_tag_i   = tag;
        l1_rsp_ready_i = 1'b0;
        chk({nm, ".accept_ready"}, l1_req_ready_o, 1);
        @(negedge clk_i);
        l1_req_valid_i = 1'b0;
        cyc = 1;
        while (cyc < 200 && !l1_rsp_valid_o) begin
            if (l1_req_ready_o !== 1'b0) chk({nm, ".busy_ready"}, l1_req_ready_o, 0);
            g = 1'b0;
            if (bus_req_o) begin
                if (issued >= 4) chk({nm, ".extra_beat"}, bus_req_o, 0);
                chk({nm, ".bus_addr"}, bus_addr_o, exp_addr0 + 32'(4 * issued));
                g = rnd ? 1'($urandom_range(0, 1)) : (stall >= gnt_stall);
            end else if (issued < 4) begin
                chk({nm, ".bus_req_missing"}, bus_req_o, 1);
            end
            bus_gnt_i = g;
            if (g) begin
                due_q.push_back(cyc + 1 + (rnd ? int'($urandom_range(0, 2)) : 0));
                idx_q.push_back(issued);
                issued++;
                stall = 0;
            end else if (bus_req_o) begin
                stall++;
            end
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                bus_rvalid_i = 1'b1;
                bus_rdata_i  = d[idx_q[0]];
                void'(due_q.pop_front());
                void'(idx_q.pop_front());
                rcvd++;
            end else begin
                bus_rvalid_i = 1'b0;
                bus_rdata_i  = $urandom;
            end
            @(negedge clk_i);
            cyc++;
        end
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        if (!l1_rsp_valid_o) begin
            chk({nm, ".timeout"}, l1_rsp_valid_o, 1);
            return;
        end
        chk({nm, ".beats_before_rsp"}, rcvd, 4);
        if (!rnd && gnt_stall == 0) chk({nm, ".latency"}, cyc, 6);
        chk({nm, ".rsp_data"}, l1_rsp_data_o, exp_line);
        chk({nm, ".rsp_tag"}, l1_rsp_tag_o, tag);
        for (int k = 0; k < rsp_stall; k++) begin
            @(negedge clk_i);
            chk({nm, ".hold_valid"}, l1_rsp_valid_o, 1);
            chk({nm, ".hold_data"}, l1_rsp_data_o, exp_line);
            chk({nm, ".hold_tag"}, l1_rsp_tag_o, tag);
            chk({nm, ".hold_req_ready"}, l1_req_ready_o, 0);
        end
        l1_rsp_ready_i = 1'b1;
        @(negedge clk_i);
        l1_rsp_ready_i = 1'b0;
        chk({nm, ".idle_rsp_valid"}, l1_rsp_valid_o, 0);
        chk({nm, ".idle_req_ready"}, l1_req_ready_o, 1);
        chk({nm, ".idle_bus_req"}, bus_req_o, 0);
    endtask

    logic [3:0][31:0] rd;
    logic [27:0]      ra;
    logic [7:0]       rt;

    initial begin
        vecs[0] = '{addr: 28'h0000010, tag: 8'h5A, d: {32'h44, 32'h33, 32'h22, 32'h11},
                    gnt_stall: 8'd0, rsp_stall: 8'd0, exp_addr0: 32'h00000100,
                    exp_line: 128'h00000044_00000033_00000022_00000011};
        vecs[1] = '{addr: 28'h1234567, tag: 8'h3C,
                    d: {32'hAAAA0004, 32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001},
                    gnt_stall: 8'd3, rsp_stall: 8'd0, exp_addr0: 32'h12345670,
                    exp_line: 128'hAAAA0004_AAAA0003_AAAA0002_AAAA0001};
        vecs[2] = '{addr: 28'h0ABCDEF, tag: 8'hC3,
                    d: {32'hCAFE0003, 32'hBEEF0002, 32'hFACE0001, 32'hF00D0000},
                    gnt_stall: 8'd0, rsp_stall: 8'd5, exp_addr0: 32'h0ABCDEF0,
                    exp_line: 128'hCAFE0003_BEEF0002_FACE0001_F00D0000};
        vecs[3] = '{addr: 28'hFFFFFFF, tag: 8'hFF,
                    d: {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A},
                    gnt_stall: 8'd1, rsp_stall: 8'd1, exp_addr0: 32'hFFFFFFF0,
                    exp_line: 128'h0000000D_0000000C_0000000B_0000000A};

        rst_ni = 1'b0;
        l1_req_valid_i = 1'b0; l1_req_rw_i = 1'b0; l1_req_byteen_i = '1;
        l1_req_addr_i = '0; l1_req_data_i = '0; l1_req_tag_i = '0;
        l1_rsp_ready_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
        repeat (2) @(negedge clk_i);
        chk("reset.rsp_valid", l1_rsp_valid_o, 0);
        chk("reset.bus_req", bus_req_o, 0);
        chk("reset.bus_addr", bus_addr_o, 0);
        chk("reset.rsp_data", l1_rsp_data_o, 0);
        chk("reset.wr_err", wr_err_o, 0);
        rst_ni = 1'b1;
        chk("release.req_ready", l1_req_ready_o, 1);

        for (int v = 0; v < 4; v++) begin
            refill($sformatf("vec%0d", v), vecs[v].addr, vecs[v].tag, vecs[v].d,
                   int'(vecs[v].gnt_stall), int'(vecs[v].rsp_stall), 1'b0,
                   vecs[v].exp_addr0, vecs[v].exp_line);
        end

        // Write request: flagged, no bus traffic, no response
        l1_req_valid_i = 1'b1; l1_req_rw_i = 1'b1; l1_req_addr_i = 28'h0000300; l1_req_tag_i = 8'h99;
        chk("write.accept_ready", l1_req_ready_o, 1);
        @(negedge clk_i);
        l1_req_valid_i = 1'b0; l1_req_rw_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("write.wr_err", wr_err_o, 1);
            chk("write.bus_req", bus_req_o, 0);
            chk("write.rsp_valid", l1_rsp_valid_o, 0);
            chk("write.req_ready", l1_req_ready_o, 1);
            @(negedge clk_i);
        end
        refill("after_write", 28'h0000040, 8'h21, {32'h4, 32'h3, 32'h2, 32'h1}, 0, 0, 1'b0,
               32'h00000400, 128'h00000004_00000003_00000002_00000001);
        chk("after_write.wr_err", wr_err_o, 1);

        // Randomized refills against the line model: base = addr*16, line = beats in order
        for (int n = 0; n < 20; n++) begin
            ra = 28'($urandom);
            rt = 8'($urandom);
            for (int b = 0; b < 4; b++) rd[b] = $urandom;
            refill($sformatf("rand%0d", n), ra, rt, rd, 0, int'($urandom_range(0, 3)), 1'b1,
                   {ra, 4'h0}, {rd[3], rd[2], rd[1], rd[0]});
        end

        // Reset in the middle of a fetch
        l1_req_valid_i = 1'b1; l1_req_addr_i = 28'h0000200; l1_req_tag_i = 8'h77;
        chk("midrst.accept_ready", l1_req_ready_o, 1);
        @(negedge clk_i);
        l1_req_valid_i = 1'b0;
        chk("midrst.addr0", bus_addr_o, 32'h00002000);
        bus_gnt_i = 1'b1;
        @(negedge clk_i);
        chk("midrst.addr1", bus_addr_o, 32'h00002004);
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEAD0000;
        @(negedge clk_i);
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("midrst.bus_req", bus_req_o, 0);
        chk("midrst.bus_addr", bus_addr_o, 0);
        chk("midrst.rsp_valid", l1_rsp_valid_o, 0);
        chk("midrst.rsp_data", l1_rsp_data_o, 0);
        chk("midrst.rsp_tag", l1_rsp_tag_o, 0);
        chk("midrst.wr_err", wr_err_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'hBAD0BAD0;
        repeat (2) @(negedge clk_i);
        bus_rvalid_i = 1'b0;
        chk("late_rvalid.rsp_valid", l1_rsp_valid_o, 0);
        chk("late_rvalid.bus_req", bus_req_o, 0);
        chk("late_rvalid.line", l1_rsp_data_o, 0);
        chk("late_rvalid.req_ready", l1_req_ready_o, 1);
        refill("after_reset", 28'h0000200, 8'h78, {32'h13, 32'h12, 32'h11, 32'h10}, 0, 2, 1'b0,
               32'h00002000, 128'h00000013_00000012_00000011_00000010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
